nonce_result_writer: RTL and testbench
======================================

NONCE_RESULT_WRITER -- requirements
Module: nonce_result_writer

Interface
REQ-001 SHALL have parameter NUM_NONCES, default 16, number of H0 words per batch.
REQ-002 SHALL have parameter NONCE_BASE, default 0, nonce value of lane 0.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  hash batch available.
REQ-006 SHALL have port in_ready  output  1  block can accept a batch.
REQ-007 SHALL have port in_h0  input  32*NUM_NONCES  H0 word per nonce lane, lane i at bits [32i+31:32i].
REQ-008 SHALL have port output_addr  input  16  base address of the result area.
REQ-009 SHALL have port mem_clk  output  1  equal to clk.
REQ-010 SHALL have port mem_we  output  1  memory write strobe.
REQ-011 SHALL have port mem_addr  output  16  write address.
REQ-012 SHALL have port mem_write_data  output  32  write data.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a batch is fully written.

Function
REQ-014 SHALL implement states IDLE, WRITE, BEST_NONCE, BEST_HASH, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, in_valid=1 SHALL capture in_h0 and output_addr, clear the index, and move to WRITE.
REQ-017 in_valid SHALL be ignored in every state other than IDLE.
REQ-018 In WRITE, each cycle SHALL drive mem_we=1, mem_addr=addr+idx, and mem_write_data=h0[idx], then increment idx.
REQ-019 WRITE SHALL last exactly NUM_NONCES cycles, then go to BEST_NONCE.
REQ-020 During WRITE, a running minimum SHALL track the smallest h0 (unsigned) and its index.
REQ-021 The minimum update SHALL use strict less-than, so on ties the lowest index wins.
REQ-022 BEST_NONCE SHALL write NONCE_BASE+best_idx (32-bit) to addr+NUM_NONCES.
REQ-023 BEST_HASH SHALL write best h0 to addr+NUM_NONCES+1.
REQ-024 DONE SHALL hold mem_we=0 and done=1 for exactly one cycle, then return to IDLE.
REQ-025 Latency SHALL be: capture at edge 0, writes on cycles 1..NUM_NONCES+2, done on cycle NUM_NONCES+3.
REQ-026 Address arithmetic SHALL be 16-bit modulo 2^16, wrapping without error.
REQ-027 mem_we SHALL be 0 in IDLE and DONE.
REQ-028 mem_addr and mem_write_data SHALL be don't-care when mem_we=0, but SHALL not toggle from X.
REQ-029 A new batch SHALL be accepted in the cycle after DONE, giving back-to-back throughput of NUM_NONCES+4 cycles.

Reset
REQ-030 Reset SHALL force state IDLE, in_ready=1, mem_we=0, done=0, mem_addr=0, mem_write_data=0, idx=0, best=FFFFFFFF, best_idx=0.
REQ-031 Reset asserted mid-batch SHALL abort immediately, with no further writes and no done pulse after release.

Structure
REQ-032 bitcoin_pkg SHALL hold NUM_NONCES default, the writer state enum, and the result-area offsets (NUM_NONCES, NUM_NONCES+1).
REQ-033 The running-minimum compare/update SHALL be a sub-module hash_min_tracker with clear, valid, value, and index inputs and best value/index outputs.

Verification
REQ-034 Basic batch: h0[i]=i+1, output_addr=0x0100 -> writes 0x0100..0x010F = 1..16, 0x0110=0, 0x0111=1, done at cycle 19.
REQ-035 Tie case: h0[5]=h0[9]=0x00000010, all others 0xFFFFFFFF -> best nonce=5, best hash=0x10.
REQ-036 Wrap case: output_addr=0xFFF8 -> lane 8 written at 0x0000, best hash written at 0x0009.
REQ-037 Busy case: in_valid held high during WRITE with different data -> ignored, in_ready=0, first batch results unchanged.
REQ-038 Mid-batch reset: reset asserted at write 7 -> mem_we=0 immediately, no done pulse, in_ready=1 after release.
REQ-039 Back-to-back batches: second in_valid accepted the cycle after done -> both result areas correct, 20-cycle spacing.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce result writer: default batch size,
// writer state encoding and result-area offsets relative to the base address.
package bitcoin_pkg;

   localparam int DEFAULT_NUM_NONCES = 16;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      BEST_NONCE,
      BEST_HASH,
      DONE
   } writer_state_t;

   // The two summary words sit directly after the per-lane H0 block.
   function automatic logic [15:0] best_nonce_offset(input int num_nonces);
      return 16'(num_nonces);
   endfunction

   function automatic logic [15:0] best_hash_offset(input int num_nonces);
      return 16'(num_nonces + 1);
   endfunction

endpackage

// File: rtl/hash_min_tracker.sv
// Running unsigned minimum over a stream of (value, index) pairs; strict
// less-than keeps the earliest index on ties.
module hash_min_tracker #(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             valid,
   input  logic [31:0]      value,
   input  logic [IDX_W-1:0] index,
   output logic [31:0]      best_value,
   output logic [IDX_W-1:0] best_index
);

   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values of its neighbours, regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         best_value <= 32'hFFFF_FFFF;
         best_index <= '0;
      end else if (clear) begin
         best_value <= 32'hFFFF_FFFF;
         best_index <= '0;
      end else if (valid && (value < best_value)) begin
         best_value <= value;
         best_index <= index;
      end
   end

endmodule

// File: rtl/nonce_result_writer.sv
// Writes one batch of per-nonce H0 words to memory, followed by the nonce and
// hash of the smallest H0, then pulses done for one cycle.
module nonce_result_writer
   import bitcoin_pkg::*;
#(
   parameter int          NUM_NONCES = DEFAULT_NUM_NONCES,
   parameter logic [31:0] NONCE_BASE = 32'd0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [32*NUM_NONCES-1:0] in_h0,
   input  logic [15:0]              output_addr,
   output logic                     mem_clk,
   output logic                     mem_we,
   output logic [15:0]              mem_addr,
   output logic [31:0]              mem_write_data,
   output logic                     done
);

   localparam int IDX_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

   writer_state_t    state, state_next;
   logic [IDX_W-1:0] idx;
   logic [15:0]      addr;
   logic [31:0]      h0 [NUM_NONCES];
   logic             capture;
   logic             track_valid;
   logic [31:0]      best_value;
   logic [IDX_W-1:0] best_index;

   assign mem_clk = clk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx  <= '0;
         addr <= '0;
      end else if (capture) begin
         idx  <= '0;
         addr <= output_addr;
      end else if (state == WRITE) begin
         idx  <= idx + 1'b1;
      end
   end

   // NOTE: the lane buffer has no reset; it is only read in WRITE, which can
   // only be reached through a capture that loads every lane first.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < NUM_NONCES; i++) h0[i] <= in_h0[32*i +: 32];
      end
   end

   hash_min_tracker #(.IDX_W(IDX_W)) u_min_tracker (
      .clk        (clk),
      .reset      (reset),
      .clear      (capture),
      .valid      (track_valid),
      .value      (h0[idx]),
      .index      (idx),
      .best_value (best_value),
      .best_index (best_index)
   );

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a value held and infer a latch.
   always_comb begin
      state_next     = state;
      capture        = 1'b0;
      track_valid    = 1'b0;
      in_ready       = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      done           = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               capture    = 1'b1;
               state_next = WRITE;
            end
         end
         WRITE: begin
            mem_we         = 1'b1;
            mem_addr       = addr + 16'(idx);
            mem_write_data = h0[idx];
            track_valid    = 1'b1;
            if (idx == LAST_IDX) state_next = BEST_NONCE;
         end
         BEST_NONCE: begin
            mem_we         = 1'b1;
            mem_addr       = addr + best_nonce_offset(NUM_NONCES);
            mem_write_data = NONCE_BASE + 32'(best_index);
            state_next     = BEST_HASH;
         end
         BEST_HASH: begin
            mem_we         = 1'b1;
            mem_addr       = addr + best_hash_offset(NUM_NONCES);
            mem_write_data = best_value;
            state_next     = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_nonce_result_writer.sv
// Self-checking bench for nonce_result_writer: directed and randomized batches
// compared cycle by cycle against an expected write list built from H0 lanes.
module tb_nonce_result_writer;

   localparam int          N    = 16;
   localparam logic [31:0] BASE = 32'd0;

   typedef logic [31:0] lanes_t [N];

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [32*N-1:0]   in_h0;
   logic [15:0]       output_addr;
   logic              mem_clk;
   logic              mem_we;
   logic [15:0]       mem_addr;
   logic [31:0]       mem_write_data;
   logic              done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   nonce_result_writer #(.NUM_NONCES(N), .NONCE_BASE(BASE)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_h0          (in_h0),
      .output_addr    (output_addr),
      .mem_clk        (mem_clk),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .done           (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: N lane writes, then argmin nonce and min hash, then done.
   task automatic run_batch(input lanes_t h, input logic [15:0] base_addr,
                            input bit busy, input string name, output int cap_cyc);
      logic [15:0] exp_addr [N+2];
      logic [31:0] exp_data [N+2];
      logic [31:0] best;
      int          best_i;
      best   = h[0];
      best_i = 0;
      for (int i = 1; i < N; i++) if (h[i] < best) begin best = h[i]; best_i = i; end
      for (int i = 0; i < N; i++) begin
         exp_addr[i] = base_addr + 16'(i);
         exp_data[i] = h[i];
      end
      exp_addr[N]   = base_addr + 16'(N);
      exp_data[N]   = BASE + 32'(best_i);
      exp_addr[N+1] = base_addr + 16'(N + 1);
      exp_data[N+1] = best;

      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s ready_before: in_ready=%b want 1", name, in_ready);
      end
      for (int i = 0; i < N; i++) in_h0[32*i +: 32] = h[i];
      output_addr = base_addr;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      cap_cyc = cyc;
      if (busy) begin
         in_h0       = ~in_h0;
         output_addr = base_addr ^ 16'h5555;
      end else begin
         in_valid = 1'b0;
      end
      for (int c = 1; c <= N + 3; c++) begin
         @(negedge clk);
         if (c <= N + 2) begin
            total++;
            if (mem_we !== 1'b1 || mem_addr !== exp_addr[c-1] || mem_write_data !== exp_data[c-1]) begin
               bad++;
               $display("FAIL %s write_cycle%0d: we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                        name, c, mem_we, mem_addr, mem_write_data, exp_addr[c-1], exp_data[c-1]);
            end
            total++;
            if (done !== 1'b0 || in_ready !== 1'b0) begin
               bad++;
               $display("FAIL %s busy_flags_cycle%0d: done=%b in_ready=%b want 0 0", name, c, done, in_ready);
            end
         end else begin
            total++;
            if (done !== 1'b1 || mem_we !== 1'b0) begin
               bad++;
               $display("FAIL %s done_cycle%0d: done=%b we=%b want 1 0", name, c, done, mem_we);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_h0       = '0;
      output_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0 || mem_addr !== 16'h0 || mem_write_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_values: ready=%b we=%b done=%b addr=%h data=%h want 1 0 0 0000 00000000",
                  in_ready, mem_we, done, mem_addr, mem_write_data);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: ready=%b we=%b done=%b want 1 0 0", in_ready, mem_we, done);
      end
   endtask

   task automatic test_basic();
      lanes_t h;
      int     cap;
      for (int i = 0; i < N; i++) h[i] = 32'(i + 1);
      run_batch(h, 16'h0100, 1'b0, "basic", cap);
   endtask

   task automatic test_tie();
      lanes_t h;
      int     cap;
      for (int i = 0; i < N; i++) h[i] = 32'hFFFF_FFFF;
      h[5] = 32'h10;
      h[9] = 32'h10;
      run_batch(h, 16'h2000, 1'b0, "tie", cap);
   endtask

   task automatic test_wrap();
      lanes_t h;
      int     cap;
      for (int i = 0; i < N; i++) h[i] = $urandom;
      run_batch(h, 16'hFFF8, 1'b0, "wrap", cap);
   endtask

   task automatic test_busy();
      lanes_t h;
      int     cap;
      for (int i = 0; i < N; i++) h[i] = $urandom;
      run_batch(h, 16'h0300, 1'b1, "busy", cap);
   endtask

   task automatic test_random();
      lanes_t         h;
      int             cap;
      logic [15:0]    a;
      for (int b = 0; b < 6; b++) begin
         // Odd batches use a tiny value range so equal minima are common.
         for (int i = 0; i < N; i++) h[i] = (b % 2 == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         a = 16'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_batch(h, a, 1'b0, "random", cap);
      end
   endtask

   task automatic test_back_to_back();
      lanes_t h1, h2;
      int     cap1, cap2;
      for (int i = 0; i < N; i++) begin
         h1[i] = $urandom;
         h2[i] = $urandom;
      end
      run_batch(h1, 16'h4000, 1'b0, "b2b_first", cap1);
      run_batch(h2, 16'h4012, 1'b0, "b2b_second", cap2);
      total++;
      if (cap2 - cap1 !== N + 4) begin
         bad++;
         $display("FAIL b2b_spacing: got %0d cycles want %0d", cap2 - cap1, N + 4);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      for (int i = 0; i < N; i++) in_h0[32*i +: 32] = $urandom;
      output_addr = 16'h0500;
      in_valid    = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (8) @(negedge clk);
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0507) begin
         bad++;
         $display("FAIL midreset_write7: we=%b addr=%h want 1 0507", mem_we, mem_addr);
      end
      reset = 1'b1;
      #1;
      total++;
      if (mem_we !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL midreset_abort: we=%b done=%b ready=%b want 0 0 1", mem_we, done, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         total++;
         if (mem_we !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_after%0d: we=%b done=%b ready=%b want 0 0 1", c, mem_we, done, in_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_wrap();
      test_busy();
      test_random();
      test_back_to_back();
      test_mid_reset();
      test_basic();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
